// File: rtl/motor_cmd_driver.sv
// motor_cmd_driver: H-bridge command executor with internal PWM and dead-time coast between direction changes
module motor_cmd_driver #(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          cmd_in,
  input  logic [PWM_BITS-1:0] duty,
  output logic [3:0]          IN,
  output logic [1:0]          EN,
  output logic                busy,
  output logic                err
);
  localparam int TW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(DEAD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, COAST} state_t;
  state_t state_q, state_d;
  logic [3:0] cmd_q, cur_q, cur_d, in_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [PWM_BITS-1:0] cnt_q, duty_q;
  logic [1:0] en_q;
  logic ill_q, busy_q, err_q, legal, pwm;
  assign legal = cmd_in inside {4'b1001, 4'b1010, 4'b0101, 4'b0000};
  assign pwm   = cnt_q < duty_q;
  assign IN    = in_q;
  assign EN    = en_q;
  assign busy  = busy_q;
  assign err   = err_q;
  // input stage: illegal codes collapse to stop and raise the error flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd_q <= '0;
      ill_q <= 1'b0;
    end else begin
      cmd_q <= legal ? cmd_in : 4'b0000;
      ill_q <= !legal;
    end
  // free-running PWM counter; duty is only picked up at the period boundary
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      duty_q <= &cnt_q ? duty : duty_q;
    end
  // next-state logic; a stop always wins over an expiring coast timer
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    if (state_q == IDLE) begin
      if (cmd_q != 4'b0000) begin
        state_d = RUN;
        cur_d   = cmd_q;
      end
    end else if (state_q == RUN) begin
      if (cmd_q == 4'b0000) state_d = IDLE;
      else if (cmd_q != cur_q) begin
        state_d = COAST;
        timer_d = TLOAD;
      end
    end else begin
      timer_d = timer_q - 1'b1;
      if (cmd_q == 4'b0000) begin
        state_d = IDLE;
        timer_d = '0;
      end else if (timer_q == '0) begin
        state_d = RUN;
        cur_d   = cmd_q;
        timer_d = '0;
      end
    end
  end
  // state and registered bridge outputs, derived from the next state so they land on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      timer_q <= '0;
      in_q    <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      timer_q <= timer_d;
      in_q    <= state_d == RUN ? cur_d : 4'b0000;
      en_q    <= state_d == RUN ? {2{pwm}} : 2'b00;
      busy_q  <= state_d == COAST;
      err_q   <= ill_q;
    end
endmodule

// File: tb/tb_motor_cmd_driver.sv
// tb_motor_cmd_driver: scoreboard bench for motor_cmd_driver with cycle-indexed expected outputs
module tb_motor_cmd_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cmd_in;
  logic [7:0] duty;
  logic [3:0] IN;
  logic [1:0] EN;
  logic       busy, err;
  int ec = 0;
  int t0 = 0;
  int checks = 0;
  int failures = 0;
  int n;
  typedef struct {int c; logic [3:0] in; int en; logic busy; logic err;} exp_t;
  exp_t q[$];
  exp_t e;

  motor_cmd_driver #(.PWM_BITS(8), .DEAD_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .duty(duty),
    .IN(IN), .EN(EN), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  // edge counter; cycle index is counted from the last reset release
  always @(posedge clk) ec++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic exp_range(int a, int b, logic [3:0] in, logic bz, logic er, int d);
    for (int c = a; c <= b; c++) q.push_back('{c, in, (((c - 1) % 256) < d) ? 3 : 0, bz, er});
  endtask

  task automatic to_cyc(int c);
    while (ec - t0 < c) @(negedge clk);
  endtask

  // compare DUT outputs against every expectation due at this cycle
  always @(negedge clk)
    while (q.size() > 0 && q[0].c <= ec - t0) begin
      e = q.pop_front();
      chk($sformatf("IN@%0d", e.c), IN, e.in);
      chk($sformatf("EN@%0d", e.c), EN, e.en);
      chk($sformatf("busy@%0d", e.c), busy, e.busy);
      chk($sformatf("err@%0d", e.c), err, e.err);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_in = 4'b0000; duty = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_IN", IN, 0); chk("rst_EN", EN, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    rst = 1'b0; t0 = ec;
    exp_range(1, 1011, 4'b0000, 0, 0, 0);
    to_cyc(1010); cmd_in = 4'b1001; duty = 8'd64;
    exp_range(1012, 1024, 4'b1001, 0, 0, 0);
    exp_range(1025, 1561, 4'b1001, 0, 0, 64);
    to_cyc(1280); n = 0;
    repeat (256) begin @(negedge clk); if (EN == 2'b11) n++; end
    chk("en_high_64", n, 64);
    to_cyc(1560); cmd_in = 4'b1010;
    exp_range(1562, 1577, 4'b0000, 1, 0, 0);
    exp_range(1578, 1601, 4'b1010, 0, 0, 64);
    to_cyc(1600); cmd_in = 4'b1001;
    exp_range(1602, 1617, 4'b0000, 1, 0, 0);
    exp_range(1618, 1641, 4'b0101, 0, 0, 64);
    to_cyc(1606); cmd_in = 4'b0101;
    to_cyc(1640); cmd_in = 4'b1001;
    exp_range(1642, 1650, 4'b0000, 1, 0, 0);
    exp_range(1651, 1671, 4'b0000, 0, 0, 0);
    to_cyc(1649); cmd_in = 4'b0000;
    to_cyc(1670); cmd_in = 4'b0101;
    exp_range(1672, 1701, 4'b0101, 0, 0, 64);
    to_cyc(1700); cmd_in = 4'b0000;
    exp_range(1702, 1711, 4'b0000, 0, 0, 0);
    to_cyc(1710); cmd_in = 4'b1001;
    exp_range(1712, 1731, 4'b1001, 0, 0, 64);
    to_cyc(1730); cmd_in = 4'b1111;
    exp_range(1732, 1751, 4'b0000, 0, 1, 0);
    to_cyc(1750); cmd_in = 4'b1001; duty = 8'd200;
    exp_range(1752, 1792, 4'b1001, 0, 0, 64);
    exp_range(1793, 2048, 4'b1001, 0, 0, 200);
    exp_range(2049, 2310, 4'b1001, 0, 0, 10);
    to_cyc(1792); n = 0;
    repeat (256) begin
      @(negedge clk);
      if (ec - t0 == 1842) duty = 8'd10;
      if (EN == 2'b11) n++;
    end
    chk("en_high_200", n, 200);
    n = 0;
    repeat (256) begin @(negedge clk); if (EN == 2'b11) n++; end
    chk("en_high_10", n, 10);
    to_cyc(2310);
    @(posedge clk); #2 rst = 1'b1; #1;
    chk("arst_IN", IN, 0); chk("arst_EN", EN, 0); chk("arst_busy", busy, 0); chk("arst_err", err, 0);
    cmd_in = 4'b1010;
    repeat (3) @(negedge clk);
    rst = 1'b0; t0 = ec;
    exp_range(1, 1, 4'b0000, 0, 0, 0);
    exp_range(2, 20, 4'b1010, 0, 0, 0);
    to_cyc(25);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/motor_cmd_driver.md
Name: motor_cmd_driver

Overview:
H-bridge command executor: the receiving end of the IN/EN motor-command interface produced by the line-follower steering logic.
- Accepts a steering command (IN code) and an 8-bit duty value.
- Generates the PWM on EN internally.
- Enforces a dead-time coast between direction changes.
- Drives the physical bridge pins IN/EN.

Parameters:
PWM_BITS, 8, width of PWM counter and duty; PWM period = 2^PWM_BITS clk cycles
DEAD_CYCLES, 1000, clk cycles of forced coast (IN=0000, EN=00) between two different non-stop commands; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_in  in  4  requested bridge code: 1001 fwd, 1010 left, 0101 right, 0000 stop
duty  in  PWM_BITS  requested PWM high time in clk cycles per period
IN  out  4  registered bridge direction pins
EN  out  2  registered bridge enable pins, both legs identical
busy  out  1  high while in COAST
err  out  1  high while the registered command is illegal

Behaviour:
- Reset (async, active-high), all values applied immediately on assertion:
  - IN=0000, EN=00, busy=0, err=0.
  - State IDLE; cmd_q=0000, cur_cmd=0000.
  - pwm_cnt=0, duty_q=0, coast timer=0.
- Input stage: cmd_in is registered into cmd_q every clk.
  - Any value other than the four legal codes is treated as 0000 (stop), and err=1 is registered for as long as it persists.
- PWM:
  - pwm_cnt increments every clk, wrapping from 2^PWM_BITS-1 to 0.
  - duty_q loads duty only on the cycle pwm_cnt==2^PWM_BITS-1, so a new duty takes effect at the next period start; a mid-period duty change never alters the current period.
  - pwm = (pwm_cnt < duty_q). duty=0 gives constant low; duty=2^PWM_BITS-1 gives high for all but one cycle per period.
  - The PWM counter runs in all states; it is not reset on state change.
- States:
  - IDLE: IN=0000, EN=00. cmd_q non-stop -> RUN, with cur_cmd=cmd_q. No dead time is needed, because the bridge is already off.
  - RUN: IN=cur_cmd, EN={2{pwm}}.
    - cmd_q==stop -> IDLE immediately.
    - cmd_q non-stop and != cur_cmd -> COAST; load timer with DEAD_CYCLES-1.
    - cmd_q==cur_cmd -> stay.
  - COAST: IN=0000, EN=00, busy=1. Timer decrements each clk.
    - cmd_q==stop at any time -> IDLE immediately; timer is abandoned.
    - Timer==0 -> RUN, with cur_cmd = cmd_q sampled on that cycle (latest command wins).
    - Command changes during COAST, including a return to the previous cur_cmd, neither restart nor shorten the timer.
- Timing:
  - Coast window: IN=0000 and busy=1 for exactly DEAD_CYCLES consecutive clk cycles.
  - All outputs are registered. IN/EN/busy/err reflect a cmd_in change on the 2nd rising clk edge after it (one edge into cmd_q, one into the output registers).
  - EN follows pwm with 1 cycle of latency relative to pwm_cnt.
- Simultaneous events: a stop request in the same cycle as timer==0 -> IDLE. An illegal code is stop, so the same rule applies.
- Invariant: IN never transitions directly between two different non-zero codes; an IN=0000 period of at least DEAD_CYCLES always separates them, except via IDLE, where the gap is at least 1 cycle.
- Reset mid-COAST or mid-RUN: outputs go to their reset values immediately. After deassertion, the block behaves as from power-up, with no residual dead time.

Test Plan:
Bench uses DEAD_CYCLES=16, PWM_BITS=8.
- Reset release, cmd_in=0000, duty=0 -> IN=0000, EN=00, busy=0, err=0 held for 1000 cycles.
- cmd_in=1001, duty=64 from IDLE -> IN=1001 two edges later; after the first wrap, EN=11 for exactly 64 of every 256 cycles.
- RUN 1001, cmd_in->1010 -> IN=0000, EN=00, busy=1 for exactly 16 cycles, then IN=1010; also change cmd_in to 0101 at coast cycle 5 -> IN=0101 after the same 16 cycles.
- COAST in progress, cmd_in->0000 at coast cycle 8 -> busy=0, state IDLE, IN stays 0000; a later 0101 enters RUN with no coast.
- RUN 1001, cmd_in=1111 -> err=1, IN=0000, EN=00 two edges later; then cmd_in=1001 -> err=0, RUN with no coast.
- duty 200->10 written at pwm_cnt=50 -> the current period keeps 200 high cycles, the next period has 10; rst pulsed mid-RUN -> outputs are zero within the same cycle, asynchronously.
